// File: rtl/bg_collision_detect_if.sv
// Bus between the main FSM / level memory and the background collision detector.
// The master side drives enable, position and the RAM q; the detector drives the rest.
interface bg_collision_detect_if;
  logic        enable;
  logic [31:0] x_position;
  logic [6:0]  y_position;
  logic [2:0]  tile_code;
  logic [14:0] level_address;
  logic        done;
  logic        hit_left;
  logic        hit_right;
  logic        hit_floor;
  logic        hit_ceiling;

  modport master (
    output enable, x_position, y_position, tile_code,
    input  level_address, done, hit_left, hit_right, hit_floor, hit_ceiling
  );

  modport slave (
    input  enable, x_position, y_position, tile_code,
    output level_address, done, hit_left, hit_right, hit_floor, hit_ceiling
  );
endinterface

// File: rtl/bg_collision_detect.sv
// Background collision detector: reads eight probe tiles around the 8x8 character
// from synchronous level RAM and publishes left/right/floor/ceiling contact flags.
module bg_collision_detect #(
  parameter logic [2:0] SOLID_MIN = 3'd1
) (
  input  logic                 CLOCK_50,
  input  logic                 resetn,
  bg_collision_detect_if.slave bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PROBE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [3:0]        LAST_IDX    = 4'd8;
  localparam logic signed [7:0] SCREEN_ROWS = 8'sd120;

  // Shadow/hit bit slots; a probe pair (idx>>1) lands directly in its slot.
  localparam int F_FLOOR = 0;
  localparam int F_CEIL  = 1;
  localparam int F_LEFT  = 2;
  localparam int F_RIGHT = 3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [13:0] x_q, x_d;
  logic [6:0]  y_q, y_d;
  logic        forced_q, forced_d;
  logic        forced_val_q, forced_val_d;
  logic [3:0]  shadow_q, shadow_d;
  logic [3:0]  hit_q, hit_d;

  logic [14:0]       x_ext, px;
  logic signed [7:0] y_ext, py;
  logic              probe_forced, probe_forced_val;
  logic [14:0]       probe_addr;

  // Probe pixel for the current idx; px is 15-bit and py 8-bit signed so that
  // stepping off any edge of the world shows up in the sign/overflow bit.
  always_comb begin
    x_ext = {1'b0, x_q};
    y_ext = signed'({1'b0, y_q});
    px    = x_ext;
    py    = y_ext;
    case (idx_q[2:0])
      3'd0:    py = y_ext + 8'sd8;
      3'd1:    begin px = x_ext + 15'd7; py = y_ext + 8'sd8; end
      3'd2:    py = y_ext - 8'sd1;
      3'd3:    begin px = x_ext + 15'd7; py = y_ext - 8'sd1; end
      3'd4:    px = x_ext - 15'd1;
      3'd5:    begin px = x_ext - 15'd1; py = y_ext + 8'sd7; end
      3'd6:    px = x_ext + 15'd8;
      default: begin px = x_ext + 15'd8; py = y_ext + 8'sd7; end
    endcase

    // Above the screen reads as air; below the screen or off either world edge is solid.
    probe_forced     = py[7] | (py >= SCREEN_ROWS) | px[14];
    probe_forced_val = ~py[7];
    probe_addr       = {py[6:3], px[13:3]};
  end

  logic [3:0] prev_idx;
  logic [1:0] prev_slot;
  logic       probe_solid;
  logic [3:0] shadow_upd;

  // RAM q belongs to the probe issued one cycle earlier; its forced bit travelled with it.
  always_comb begin
    prev_idx    = idx_q - 4'd1;
    prev_slot   = prev_idx[2:1];
    probe_solid = forced_q ? forced_val_q : (bus.tile_code >= SOLID_MIN);
    shadow_upd  = shadow_q;
    if (idx_q != 4'd0) begin
      shadow_upd[prev_slot] = shadow_q[prev_slot] | probe_solid;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    x_d          = x_q;
    y_d          = y_q;
    forced_d     = forced_q;
    forced_val_d = forced_val_q;
    shadow_d     = shadow_q;
    hit_d        = hit_q;

    case (state_q)
      S_IDLE: begin
        if (bus.enable) begin
          state_d  = S_PROBE;
          idx_d    = 4'd0;
          x_d      = bus.x_position[13:0];
          y_d      = bus.y_position;
          forced_d = 1'b0;
          shadow_d = 4'd0;
        end
      end

      S_PROBE: begin
        if (idx_q == LAST_IDX) begin
          // Completion wins over a simultaneous enable drop.
          hit_d    = shadow_upd;
          shadow_d = shadow_upd;
          state_d  = S_DONE;
        end else if (!bus.enable) begin
          state_d  = S_IDLE;
          idx_d    = 4'd0;
          shadow_d = 4'd0;
        end else begin
          idx_d        = idx_q + 4'd1;
          forced_d     = probe_forced;
          forced_val_d = probe_forced_val;
          shadow_d     = shadow_upd;
        end
      end

      S_DONE: begin
        if (!bus.enable) begin
          state_d = S_IDLE;
          idx_d   = 4'd0;
        end
      end

      default: begin
        state_d = S_IDLE;
        idx_d   = 4'd0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      idx_q        <= 4'd0;
      x_q          <= 14'd0;
      y_q          <= 7'd0;
      forced_q     <= 1'b0;
      forced_val_q <= 1'b0;
      shadow_q     <= 4'd0;
      hit_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      x_q          <= x_d;
      y_q          <= y_d;
      forced_q     <= forced_d;
      forced_val_q <= forced_val_d;
      shadow_q     <= shadow_d;
      hit_q        <= hit_d;
    end
  end

  // Address is zero outside a run so the main FSM's mux sees a quiet bus.
  assign bus.level_address = (state_q == S_PROBE && !idx_q[3]) ? probe_addr : 15'd0;
  assign bus.done          = (state_q == S_DONE);
  assign bus.hit_floor     = hit_q[F_FLOOR];
  assign bus.hit_ceiling   = hit_q[F_CEIL];
  assign bus.hit_left      = hit_q[F_LEFT];
  assign bus.hit_right     = hit_q[F_RIGHT];

  logic unused_bits;
  assign unused_bits = ^{bus.x_position[31:14], px[2:0], prev_idx[3], prev_idx[0]};

endmodule

// File: tb/tb_bg_collision_detect.sv
// Scoreboard bench for bg_collision_detect: a behavioural level RAM plus a probe
// model that queues expected addresses and flags for each run.
module tb_bg_collision_detect;

  typedef struct {
    logic [14:0] addr;
    logic [2:0]  code;
  } tile_t;

  logic clk;
  logic resetn;

  bg_collision_detect_if bus ();

  bg_collision_detect #(.SOLID_MIN(3'd1)) dut (
    .CLOCK_50 (clk),
    .resetn   (resetn),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  tile_t       level_q[$];
  logic [14:0] exp_addr_q[$];
  logic [3:0]  exp_flag_q[$];
  logic [3:0]  last_flags;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic logic [14:0] mk(input int row, input int col);
    logic [3:0]  r;
    logic [10:0] c;
    r = row[3:0];
    c = col[10:0];
    return {r, c};
  endfunction

  function automatic logic [2:0] tile_at(input logic [14:0] a);
    foreach (level_q[i]) if (level_q[i].addr == a) return level_q[i].code;
    return 3'd0;
  endfunction

  // Synchronous level RAM: q follows the address presented on the previous cycle.
  initial bus.tile_code = 3'd0;
  always @(posedge clk) bus.tile_code <= tile_at(bus.level_address);

  function automatic logic [3:0] hits();
    return {bus.hit_ceiling, bus.hit_floor, bus.hit_right, bus.hit_left};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_tile(input int row, input int col, input logic [2:0] code);
    tile_t t;
    t.addr = mk(row, col);
    t.code = code;
    level_q.push_back(t);
  endtask

  // Expected flags vector: {ceiling, floor, right, left}.
  task automatic predict(input int x, input int y);
    int         dx[8] = '{0, 7, 0, 7, -1, -1, 8, 8};
    int         dy[8] = '{8, 8, -1, -1, 0, 7, 0, 7};
    int         slot[4] = '{2, 3, 0, 1};
    logic [3:0] f = 4'd0;
    for (int k = 0; k < 8; k++) begin
      int          px = x + dx[k];
      int          py = y + dy[k];
      logic [14:0] a  = mk(py >>> 3, px >>> 3);
      logic        s;
      if (py < 0)                      s = 1'b0;
      else if (py >= 120)              s = 1'b1;
      else if (px < 0 || px > 16383)   s = 1'b1;
      else                             s = (tile_at(a) >= 3'd1);
      exp_addr_q.push_back(a);
      f[slot[k/2]] = f[slot[k/2]] | s;
    end
    exp_flag_q.push_back(f);
    last_flags = f;
  endtask

  task automatic run(input string name, input int x, input int y, input bit drop_at_done);
    int lat  = -1;
    bit seen = 1'b0;
    predict(x, y);
    @(negedge clk);
    bus.x_position = x;
    bus.y_position = 7'(y);
    bus.enable     = 1'b1;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        bus.x_position = x ^ 32'h155;
        bus.y_position = 7'(y + 13);
      end
      check($sformatf("%s_addr%0d", name, k), 32'(bus.level_address), 32'(exp_addr_q.pop_front()));
    end
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
        lat  = 8 + c;
        break;
      end
      if (c == 0 && drop_at_done) bus.enable = 1'b0;
    end
    check($sformatf("%s_latency", name), 32'(lat), 32'd9);
    check($sformatf("%s_flags", name), 32'(hits()), 32'(exp_flag_q.pop_front()));
    if (!drop_at_done) begin
      @(negedge clk);
      bus.enable = 1'b0;
    end
    @(negedge clk);
    check($sformatf("%s_done_fall", name), 32'(bus.done), 32'd0);
  endtask

  task automatic abort_run(input int x, input int y);
    bit saw_done = 1'b0;
    @(negedge clk);
    bus.x_position = x;
    bus.y_position = 7'(y);
    bus.enable     = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    @(negedge clk);
    bus.enable = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_done", 32'(saw_done), 32'd0);
    check("abort_hits_kept", 32'(hits()), 32'(last_flags));
    check("abort_addr_idle", 32'(bus.level_address), 32'd0);
  endtask

  task automatic reset_mid_run(input int x, input int y);
    @(negedge clk);
    bus.x_position = x;
    bus.y_position = 7'(y);
    bus.enable     = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 resetn = 1'b0;
    #2;
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_hits", 32'(hits()), 32'd0);
    check("rst_addr", 32'(bus.level_address), 32'd0);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    last_flags = 4'd0;
    @(negedge clk);
    check("rst_hits_after", 32'(hits()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    resetn         = 1'b0;
    bus.enable     = 1'b0;
    bus.x_position = 32'd0;
    bus.y_position = 7'd0;
    last_flags     = 4'd0;
    #25;
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_hits", 32'(hits()), 32'd0);
    check("reset_addr", 32'(bus.level_address), 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run("air", 100, 50, 1'b0);

    set_tile(7, 12, 3'd2);
    run("floor_tile", 96, 48, 1'b0);

    level_q.delete();
    set_tile(15, 0, 3'd3);
    run("origin", 0, 0, 1'b0);

    level_q.delete();
    run("bottom", 200, 112, 1'b0);
    run("right_edge", 16376, 40, 1'b0);

    set_tile(7, 13, 3'd2);
    set_tile(6, 12, 3'd1);
    run("all_four", 100, 50, 1'b0);

    level_q.delete();
    abort_run(300, 60);
    run("after_abort", 300, 60, 1'b0);

    set_tile(6, 12, 3'd1);
    run("drop_at_done", 100, 50, 1'b1);

    reset_mid_run(100, 50);

    level_q.delete();
    set_tile(7, 13, 3'd2);
    run("after_reset", 100, 50, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
